// File: rtl/rob_pkg.sv
// -----------------------------------------------------------------------------
// rob_pkg
// Shared definitions for the reorder buffer: default geometry, derived index
// widths and the ROB entry record.
//
// The entry struct is sized from the ROB_* constants below. A reorder_buffer
// instance that overrides PREG_W or AREG_W must use the same values as this
// package, so change the geometry here.
// -----------------------------------------------------------------------------
package rob_pkg;

  localparam int ROB_DEPTH  = 16;
  localparam int ROB_PREG_W = 6;
  localparam int ROB_AREG_W = 5;
  localparam int ROB_IDX_W  = $clog2(ROB_DEPTH);
  // Head and tail carry one extra wrap bit above the index.
  localparam int ROB_PTR_W  = ROB_IDX_W + 1;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  has_dest;
    logic [ROB_AREG_W-1:0] dr;
    logic [ROB_PREG_W-1:0] dr_p;
    logic [ROB_PREG_W-1:0] old_dr;
  } rob_entry_t;

  // Full when the indices match and the wrap bits differ.
  function automatic logic ptr_full(input logic [ROB_PTR_W-1:0] head,
                                    input logic [ROB_PTR_W-1:0] tail);
    return (head[ROB_PTR_W-1] != tail[ROB_PTR_W-1]) &&
           (head[ROB_PTR_W-2:0] == tail[ROB_PTR_W-2:0]);
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
// In-order retirement buffer for a renamed out-of-order core. Rename allocates
// one entry per cycle at the tail, execution units mark entries done by index,
// and the head entry retires once it is done. Retirement publishes the
// architectural mapping and frees the previous physical register.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   alloc_valid         rename offers one instruction
//   alloc_has_dest      instruction writes a destination register
//   alloc_dr            architectural destination
//   alloc_dr_p          new physical destination
//   alloc_old_dr        previous physical mapping of alloc_dr
//   alloc_ready         buffer not full (allocation handshake)
//   alloc_rob_idx       index the current allocation receives (tail)
//   complete_valid      completion report
//   complete_idx        index being completed
//   retire_valid        head entry retires this cycle
//   retire_areg         architectural register committed
//   retire_preg         physical register committed
//   retire_free_valid   retire_free_preg returns to the free pool
//   retire_free_preg    old physical register released
//   flush               discard all entries
//   count               occupied entries (0..DEPTH)
// -----------------------------------------------------------------------------
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int PREG_W = ROB_PREG_W,
  parameter int AREG_W = ROB_AREG_W
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic                     alloc_valid,
  input  logic                     alloc_has_dest,
  input  logic [AREG_W-1:0]        alloc_dr,
  input  logic [PREG_W-1:0]        alloc_dr_p,
  input  logic [PREG_W-1:0]        alloc_old_dr,
  output logic                     alloc_ready,
  output logic [$clog2(DEPTH)-1:0] alloc_rob_idx,

  input  logic                     complete_valid,
  input  logic [$clog2(DEPTH)-1:0] complete_idx,

  output logic                     retire_valid,
  output logic [AREG_W-1:0]        retire_areg,
  output logic [PREG_W-1:0]        retire_preg,
  output logic                     retire_free_valid,
  output logic [PREG_W-1:0]        retire_free_preg,

  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W:0]   head;
  logic [IDX_W:0]   tail;
  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;
  logic             full;
  logic             alloc_fire;
  logic             complete_hit;
  rob_entry_t       head_ent;
  rob_entry_t       new_ent;

  // Entry storage. Only valid/done are reset; payload fields are written on
  // allocation and are meaningless while valid is low.
  rob_entry_t       ent [DEPTH];

  assign head_idx = head[IDX_W-1:0];
  assign tail_idx = tail[IDX_W-1:0];
  assign full     = ptr_full(head, tail);

  // Occupancy falls straight out of the wrap-extended pointers; the modulo
  // 2*DEPTH subtraction yields DEPTH when full and 0 when empty.
  assign count    = tail - head;

  // Allocation side. alloc_ready looks only at the registered pointers, so a
  // retire in the same cycle does not open a slot until the next cycle.
  assign alloc_ready   = !full;
  assign alloc_rob_idx = tail_idx;
  assign alloc_fire    = alloc_valid && !full && !flush;

  // Completions aimed at empty slots (stale or already flushed) are dropped.
  assign complete_hit  = complete_valid && ent[complete_idx].valid;

  always_comb begin
    new_ent          = '0;
    new_ent.valid    = 1'b1;
    new_ent.done     = 1'b0;
    new_ent.has_dest = alloc_has_dest;
    new_ent.dr       = alloc_dr;
    new_ent.dr_p     = alloc_dr_p;
    new_ent.old_dr   = alloc_old_dr;
  end

  // Retire side: purely combinational from the head entry. Flush suppresses
  // retirement, and every retire output is forced to zero when not retiring.
  assign head_ent = ent[head_idx];

  always_comb begin
    retire_valid      = 1'b0;
    retire_areg       = '0;
    retire_preg       = '0;
    retire_free_valid = 1'b0;
    retire_free_preg  = '0;
    if (!flush && head_ent.valid && head_ent.done) begin
      retire_valid      = 1'b1;
      retire_areg       = head_ent.dr;
      retire_preg       = head_ent.dr_p;
      retire_free_valid = head_ent.has_dest;
      retire_free_preg  = head_ent.old_dr;
    end
  end

  // State update: flush outranks everything; otherwise completion, retire
  // and allocation all land on the same edge. Allocation never targets a
  // valid slot (it requires !full), so its write cannot collide with the
  // completion or retire writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent[i].valid <= 1'b0;
        ent[i].done  <= 1'b0;
      end
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent[i].valid <= 1'b0;
        ent[i].done  <= 1'b0;
      end
    end else begin
      if (complete_hit) begin
        ent[complete_idx].done <= 1'b1;
      end
      if (retire_valid) begin
        ent[head_idx].valid <= 1'b0;
        ent[head_idx].done  <= 1'b0;
        head                <= head + 1'b1;
      end
      if (alloc_fire) begin
        ent[tail_idx] <= new_ent;
        tail          <= tail + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;

  localparam int DEPTH  = 16;
  localparam int PREG_W = 6;
  localparam int AREG_W = 5;
  localparam int IW     = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              alloc_valid = 1'b0;
  logic              alloc_has_dest = 1'b0;
  logic [AREG_W-1:0] alloc_dr = '0;
  logic [PREG_W-1:0] alloc_dr_p = '0;
  logic [PREG_W-1:0] alloc_old_dr = '0;
  logic              alloc_ready;
  logic [IW-1:0]     alloc_rob_idx;
  logic              complete_valid = 1'b0;
  logic [IW-1:0]     complete_idx = '0;
  logic              retire_valid;
  logic [AREG_W-1:0] retire_areg;
  logic [PREG_W-1:0] retire_preg;
  logic              retire_free_valid;
  logic [PREG_W-1:0] retire_free_preg;
  logic              flush = 1'b0;
  logic [IW:0]       count;

  always #5 clk = ~clk;

  reorder_buffer #(.DEPTH(DEPTH), .PREG_W(PREG_W), .AREG_W(AREG_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .alloc_valid       (alloc_valid),
    .alloc_has_dest    (alloc_has_dest),
    .alloc_dr          (alloc_dr),
    .alloc_dr_p        (alloc_dr_p),
    .alloc_old_dr      (alloc_old_dr),
    .alloc_ready       (alloc_ready),
    .alloc_rob_idx     (alloc_rob_idx),
    .complete_valid    (complete_valid),
    .complete_idx      (complete_idx),
    .retire_valid      (retire_valid),
    .retire_areg       (retire_areg),
    .retire_preg       (retire_preg),
    .retire_free_valid (retire_free_valid),
    .retire_free_preg  (retire_free_preg),
    .flush             (flush),
    .count             (count)
  );

  // Reference model: program-order list of in-flight instructions.
  typedef struct {
    int idx;
    int areg;
    int preg;
    bit has_dest;
    int old;
    bit done;
  } ment_t;

  typedef struct {
    int areg;
    int preg;
    bit fv;
    int fp;
  } exp_t;

  ment_t mq[$];
  exp_t  exp_q[$];
  int    mtail = 0;
  int    total = 0;
  int    bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on the same edge the DUT commits; inputs are stable here.
  always @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      mq.delete();
      exp_q.delete();
      mtail = 0;
    end else begin
      bit    ret;
      bit    acc;
      ment_t m;
      exp_t  e;
      ret = (mq.size() > 0) && mq[0].done;
      acc = alloc_valid && (mq.size() < DEPTH);
      if (complete_valid)
        foreach (mq[i]) if (mq[i].idx == int'(complete_idx)) mq[i].done = 1;
      if (ret) void'(mq.pop_front());
      if (acc) begin
        m.idx = mtail; m.areg = alloc_dr; m.preg = alloc_dr_p;
        m.has_dest = alloc_has_dest; m.old = alloc_old_dr; m.done = 0;
        mq.push_back(m);
        e.areg = alloc_dr; e.preg = alloc_dr_p;
        e.fv = alloc_has_dest; e.fp = alloc_old_dr;
        exp_q.push_back(e);
        mtail = (mtail + 1) % DEPTH;
      end
    end
  end

  // Monitor: compares status every cycle and pops the scoreboard whenever
  // the DUT presents a retirement.
  always @(negedge clk) begin
    bit   er;
    exp_t e;
    er = !rst && !flush && (mq.size() > 0) && mq[0].done;
    chk("count", count, mq.size());
    chk("alloc_ready", alloc_ready, mq.size() < DEPTH);
    chk("alloc_rob_idx", alloc_rob_idx, mtail);
    chk("retire_valid", retire_valid, er);
    if (retire_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL retire_order: retire seen with no instruction outstanding at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("retire_areg", retire_areg, e.areg);
        chk("retire_preg", retire_preg, e.preg);
        chk("retire_free_valid", retire_free_valid, e.fv);
        chk("retire_free_preg", retire_free_preg, e.fp);
      end
    end else begin
      chk("idle_retire_outputs",
          {retire_free_valid, retire_areg, retire_preg, retire_free_preg}, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 0;
    complete_valid = 0;
    flush = 0;
  endtask

  task automatic set_alloc(input int dr, input int p, input int old, input bit hd);
    alloc_valid    = 1;
    alloc_dr       = AREG_W'(dr);
    alloc_dr_p     = PREG_W'(p);
    alloc_old_dr   = PREG_W'(old);
    alloc_has_dest = hd;
  endtask

  task automatic do_flush();
    idle();
    flush = 1;
    tick();
    flush = 0;
  endtask

  initial begin
    bit acc;

    // Reset
    idle();
    tick();
    tick();
    chk("rst_count", count, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_retire_valid", retire_valid, 0);
    rst = 0;

    // First allocation and its retirement
    set_alloc(5, 40, 5, 1);
    chk("first_idx", alloc_rob_idx, 0);
    tick();
    idle();
    chk("first_count", count, 1);
    chk("first_no_retire", retire_valid, 0);
    complete_valid = 1;
    complete_idx = 0;
    tick();
    idle();
    chk("first_retire_valid", retire_valid, 1);
    chk("first_retire_areg", retire_areg, 5);
    chk("first_retire_preg", retire_preg, 40);
    chk("first_free_valid", retire_free_valid, 1);
    chk("first_free_preg", retire_free_preg, 5);
    tick();
    chk("first_count_after", count, 0);

    // Fill to capacity, 17th request ignored
    do_flush();
    for (int i = 0; i < DEPTH; i++) begin
      set_alloc($urandom, $urandom, $urandom, 1'($urandom));
      tick();
    end
    chk("full_ready", alloc_ready, 0);
    chk("full_count", count, DEPTH);
    chk("full_tail_wrap", alloc_rob_idx, 0);
    set_alloc(7, 7, 7, 1);
    tick();
    chk("full_17th_ignored", count, DEPTH);

    // Complete head while allocation held: accepted the cycle after retire
    complete_valid = 1;
    complete_idx = 0;
    tick();
    complete_valid = 0;
    chk("full_retire_valid", retire_valid, 1);
    chk("full_ready_during_retire", alloc_ready, 0);
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      if (alloc_ready) begin
        acc = 1;
        tick();
        break;
      end
      tick();
      chk("count_le_depth", count <= DEPTH, 1);
    end
    chk("late_alloc_accepted", acc, 1);
    chk("late_alloc_count", count, DEPTH);
    idle();

    // Out-of-order completion retires in order
    do_flush();
    set_alloc(1, 11, 21, 1);
    tick();
    set_alloc(2, 12, 22, 0);
    tick();
    idle();
    complete_valid = 1;
    complete_idx = 1;
    tick();
    idle();
    chk("ooo_no_retire_a", retire_valid, 0);
    tick();
    chk("ooo_no_retire_b", retire_valid, 0);
    complete_valid = 1;
    complete_idx = 0;
    tick();
    idle();
    chk("ooo_retire0_valid", retire_valid, 1);
    chk("ooo_retire0_preg", retire_preg, 11);
    tick();
    chk("ooo_retire1_valid", retire_valid, 1);
    chk("ooo_retire1_preg", retire_preg, 12);
    chk("ooo_retire1_free", retire_free_valid, 0);
    tick();
    chk("ooo_count", count, 0);

    // Flush with completed entries pending
    do_flush();
    for (int i = 0; i < 3; i++) begin
      set_alloc(i + 3, i + 30, i + 50, 1);
      tick();
    end
    idle();
    complete_valid = 1;
    complete_idx = 1;
    tick();
    complete_idx = 0;
    tick();
    idle();
    chk("flush_pre_count", count, 3);
    flush = 1;
    #1;
    chk("flush_retire_gated", retire_valid, 0);
    tick();
    flush = 0;
    chk("flush_count", count, 0);
    chk("flush_tail", alloc_rob_idx, 0);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 4; i++) begin
      set_alloc($urandom, $urandom, $urandom, 1);
      complete_valid = 1;
      complete_idx = IW'(i);
      tick();
    end
    idle();
    @(negedge clk);
    #2;
    rst = 1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_retire_valid", retire_valid, 0);
    chk("arst_alloc_ready", alloc_ready, 1);
    chk("arst_alloc_idx", alloc_rob_idx, 0);
    tick();
    rst = 0;
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      alloc_valid    = ($urandom % 4) != 0;
      alloc_dr       = AREG_W'($urandom);
      alloc_dr_p     = PREG_W'($urandom);
      alloc_old_dr   = PREG_W'($urandom);
      alloc_has_dest = 1'($urandom);
      complete_valid = ($urandom % 3) != 0;
      if (mq.size() > 0 && ($urandom % 5) != 0)
        complete_idx = IW'(mq[$urandom % mq.size()].idx);
      else
        complete_idx = IW'($urandom);
      flush = ($urandom % 100) == 0;
      tick();
    end
    idle();
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter DEPTH, default 16, number of ROB entries (power of two).
REQ-002 Parameter PREG_W, default 6, physical register index width.
REQ-003 Parameter AREG_W, default 5, architectural register index width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 alloc_valid  in  1  rename presents one instruction for allocation.
REQ-007 alloc_has_dest  in  1  instruction writes a destination register.
REQ-008 alloc_dr  in  AREG_W  architectural destination register.
REQ-009 alloc_dr_p  in  PREG_W  newly mapped physical destination register.
REQ-010 alloc_old_dr  in  PREG_W  previous physical mapping of alloc_dr.
REQ-011 alloc_ready  out  1  ROB not full; allocation is accepted only when alloc_valid and alloc_ready are both high.
REQ-012 alloc_rob_idx  out  log2(DEPTH)  index the current allocation receives (the tail).
REQ-013 complete_valid  in  1  an execution unit reports completion.
REQ-014 complete_idx  in  log2(DEPTH)  ROB index being completed.
REQ-015 retire_valid  out  1  head entry retires this cycle.
REQ-016 retire_areg  out  AREG_W  architectural register committed.
REQ-017 retire_preg  out  PREG_W  physical register committed to retire_areg.
REQ-018 retire_free_valid  out  1  retire_free_preg returns to the free pool.
REQ-019 retire_free_preg  out  PREG_W  old physical register released.
REQ-020 flush  in  1  discard all entries.
REQ-021 count  out  log2(DEPTH)+1  number of occupied entries.

Function
REQ-022 Circular buffer; head and tail pointers carry one extra wrap bit; full when indices match and wrap bits differ; empty when the pointers are equal.
REQ-023 On an accepted allocation, the entry at tail stores {valid=1, done=0, has_dest, dr, dr_p, old_dr}, and tail increments modulo 2*DEPTH at the edge.
REQ-024 alloc_ready = !full, combinational; a simultaneous retire does not free a slot for the same cycle's allocation.
REQ-025 complete_valid to an entry with valid=1 sets done=1 at the edge; completion to an invalid entry is ignored.
REQ-026 retire_valid = head entry valid && done, combinational; retire_areg, retire_preg and retire_free_preg are taken from the head entry; retire_free_valid = retire_valid && has_dest.
REQ-027 When retire_valid is high, the head entry is invalidated and head increments at the edge; at most one retire per cycle.
REQ-028 Completion of the head entry in cycle N makes retire_valid high in cycle N+1 (minimum one-cycle complete-to-retire latency).
REQ-029 Allocation and retire in the same cycle leave count unchanged; count otherwise increments or decrements by one.
REQ-030 flush has priority over allocation, completion and retire: all valid bits clear, head=tail=0, and no retire outputs are asserted in that cycle.
REQ-031 All retire outputs are 0 whenever retire_valid is 0.

Reset
REQ-032 While rst is high: head=0, tail=0, count=0, all valid/done bits 0, retire_valid=0, retire_free_valid=0, alloc_ready=1, alloc_rob_idx=0.
REQ-033 Reset asserted mid-operation discards all entries immediately; the first edge after deassertion behaves as from empty.

Structure
REQ-034 Shared package rob_pkg holds DEPTH, PREG_W, AREG_W, the derived index width, and the ROB entry struct type.
REQ-035 Single module; no sub-module. Entry storage is a flop array inside reorder_buffer.

Verification
REQ-036 Reset, then allocate dr=5, dr_p=40, old=5, has_dest=1 -> alloc_rob_idx=0, count=1, retire_valid=0.
REQ-037 Complete idx 0 in cycle N -> cycle N+1: retire_valid=1, areg=5, preg=40, free_valid=1, free_preg=5; cycle N+2: count=0.
REQ-038 Allocate 16 entries -> alloc_ready=0, count=16; a 17th alloc_valid is ignored; tail wraps to 0.
REQ-039 Allocate idx 0,1; complete idx 1 only -> no retire; then complete idx 0 -> retires 0 then 1 on consecutive cycles, in order.
REQ-040 Fill to 16 entries, complete head, and hold alloc_valid -> the allocation is accepted in the cycle after the retire; count stays ≤16.
REQ-041 Allocate 3 entries, complete 2, assert flush -> count=0, retire_valid=0, next alloc_rob_idx=0.
